scan_mux: RTL and testbench
===========================

Name: scan_mux

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer; successor to the fixed 8:1 combinational mux.
- Two modes:
  - Manual: the external select picks the channel.
  - Scan: an internal pointer steps through all channels, holding each for DWELL cycles.
- Output is registered with valid and channel tag.
- Feeds time-multiplexed monitor/display paths in the lab designs.

Parameters:
- N_CH, 8, number of input channels (>=2; need not be a power of 2).
- WIDTH, 1, bits per channel.
- DWELL, 4, cycles each channel is held in scan mode (>=1).
- SEL_W, $clog2(N_CH), localparam, select/pointer width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  N_CH*WIDTH  packed channels; channel k = in[k*WIDTH +: WIDTH].
- s  input  SEL_W  manual-mode channel select.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  scan advance enable; 0 freezes pointer and dwell counter.
- y  output  WIDTH  registered selected data.
- y_valid  output  1  y holds a legal channel.
- y_ch  output  SEL_W  channel index that produced y.
- wrap  output  1  one-cycle pulse when the scan pointer wraps N_CH-1 -> 0.

Behaviour:
- Single clock (clk); synchronous active-high reset (rst), sampled only on rising clk.
- Reset values: y=0, y_valid=0, y_ch=0, wrap=0, ptr=0, dwell=0, state=MANUAL.
- Latency: 1 cycle. Outputs at edge t+1 reflect in/s/mode sampled at edge t. No combinational input-to-output path.
- FSM states:
  - MANUAL: mode=1 -> SCAN; else stay.
  - SCAN: mode=0 -> MANUAL; else stay.
- MANUAL mode:
  - s < N_CH: y<=in[s], y_ch<=s, y_valid<=1.
  - s >= N_CH: y<=0, y_ch<=s, y_valid<=0.
  - wrap=0.
- Entering SCAN (the cycle state changes MANUAL->SCAN): ptr<=0, dwell<=0; output that cycle is channel 0.
- SCAN mode, output: y<=in[ptr], y_ch<=ptr, y_valid<=1 every cycle. Data is live; it follows in[ptr] even while frozen.
- SCAN mode, with en=1:
  - dwell < DWELL-1: dwell++.
  - dwell == DWELL-1: dwell<=0 and ptr advances.
  - ptr == N_CH-1 at advance: ptr<=0 and wrap<=1 for exactly one cycle.
- SCAN mode, with en=0: ptr and dwell hold; wrap=0.
- DWELL=1: ptr advances every enabled cycle.
- Leaving SCAN mid-dwell: the next output is manual; ptr/dwell are discarded (re-zeroed on the next entry).
- rst asserted in any state or mid-dwell forces reset values on that edge, overriding mode/en.
- All counters are sized to avoid overflow. The dwell counter width is $clog2(DWELL)+1.

Optional Feature:
- Macro: SCAN_MUX_MASK_EN.
- When defined:
  - Adds input ch_mask [N_CH-1:0]; 1 = channel enabled.
  - Scan advance moves ptr to the next enabled channel above ptr, circularly.
  - wrap pulses when the search passes index N_CH-1.
  - Entering SCAN selects the lowest enabled channel.
  - If ch_mask==0: y=0, y_valid=0, ptr and dwell hold.
  - Manual select of a masked channel: y=0, y_valid=0.
  - A mask change mid-dwell takes effect at the next advance. The current channel continues even if just masked.
- When undefined: no ch_mask port; every channel is enabled; behaviour exactly as above.

Decomposition:
- Shared package scan_mux_pkg holds:
  - mode encoding constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1;
  - state typedef {ST_MANUAL, ST_SCAN};
  - function next_enabled(ptr, mask) used by the mask feature.
- One sub-module, scan_mux_ptr: dwell counter + pointer + wrap generation (+ mask search). The top level holds the FSM, data select and output registers.

Test Plan:
- Reset and manual sweep: rst=1 for 2 cycles -> y=0, y_valid=0, y_ch=0. Then N_CH=8, WIDTH=1, in=8'b0000_0100, s=2 -> next cycle y=1, y_ch=2, y_valid=1. Then s=3 -> y=0.
- Out-of-range select: N_CH=6, s=7 -> y=0, y_valid=0, y_ch=7.
- Scan with dwell: N_CH=8, DWELL=4, mode=1, en=1, in=8'hA5.
  - y_ch sequence 0,0,0,0,1,1,1,1,...,7 repeats.
  - wrap=1 exactly on the cycle y_ch returns to 0, after 32 cycles.
  - y follows the A5 bits.
- Freeze and mid-scan mode switch:
  - en=0 for 5 cycles at ptr=3 -> y_ch stays 3, wrap=0; dwell resumes where it stopped.
  - mode=0 at ptr=5, s=1 -> next cycle y_ch=1.
  - mode=1 again -> restarts at y_ch=0.
- Reset mid-scan: rst=1 while ptr=6, dwell=2 -> next cycle all outputs 0, state MANUAL.
- SCAN_MUX_MASK_EN with ch_mask=8'b1001_0010 and DWELL=1:
  - y_ch sequence 1,4,7,1; wrap pulses on 7->1.
  - ch_mask=0 -> y_valid=0, ptr held.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared mode encodings, FSM state type and circular channel search for scan_mux.
package scan_mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  localparam int MAX_CH = 64;
  localparam int MAX_W = 6;
  typedef enum logic {ST_MANUAL, ST_SCAN} state_t;
  // First enabled channel strictly above ptr, searching circularly; returns ptr when none is enabled.
  function automatic int next_enabled(input int ptr, input logic [MAX_CH-1:0] mask, input int n);
    int k;
    logic found;
    next_enabled = ptr;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      k = ptr + i;
      if (k >= n) k = k - n;
      if (i <= n && !found && mask[k[MAX_W-1:0]]) begin
        next_enabled = k;
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/scan_mux_ptr.sv
// scan_mux_ptr: scan pointer, dwell counter and wrap pulse; ptr_next is the pointer after this edge.
module scan_mux_ptr import scan_mux_pkg::*; #(
  parameter int N_CH = 8,
  parameter int DWELL = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic             en,
  input  logic [N_CH-1:0]  mask,
  output logic [SEL_W-1:0] ptr_next,
  output logic             wrap
);
  localparam int DW = $clog2(DWELL) + 1;
  logic [SEL_W-1:0] ptr, first, nxt;
  logic [DW-1:0] dwell, dwell_next;
  logic any, step, adv;
  assign any = |mask;
  assign step = run && en && any;
  assign adv = step && dwell == DW'(DWELL - 1);
  assign first = SEL_W'(next_enabled(N_CH - 1, MAX_CH'(mask), N_CH));
  assign nxt = SEL_W'(next_enabled(int'(ptr), MAX_CH'(mask), N_CH));
  always_comb begin
    dwell_next = (start || adv) ? '0 : step ? dwell + 1'b1 : dwell;
    ptr_next = start ? (any ? first : '0) : adv ? nxt : ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      dwell <= '0;
      wrap <= 1'b0;
    end else begin
      ptr <= ptr_next;
      dwell <= dwell_next;
      wrap <= adv && nxt <= ptr;
    end
  end
endmodule

// File: rtl/scan_mux.sv
// scan_mux: N-channel registered mux with manual select and dwell-timed scan mode.
// Optional SCAN_MUX_MASK_EN adds ch_mask to skip disabled channels.
module scan_mux import scan_mux_pkg::*; #(
  parameter int N_CH = 8,
  parameter int WIDTH = 1,
  parameter int DWELL = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
`ifdef SCAN_MUX_MASK_EN
  input  logic [N_CH-1:0]       ch_mask,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]      s,
  input  logic                  mode,
  input  logic                  en,
  output logic [WIDTH-1:0]      y,
  output logic                  y_valid,
  output logic [SEL_W-1:0]      y_ch,
  output logic                  wrap
);
  localparam int NP = 2 ** SEL_W;
  state_t state, state_next;
  logic [N_CH-1:0] mask;
  logic [NP*WIDTH-1:0] in_pad;
  logic [NP-1:0] mask_pad;
  logic [SEL_W-1:0] ptr_next, ch_d;
  logic [WIDTH-1:0] y_d;
  logic v_d, scan, start, run;
`ifdef SCAN_MUX_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif
  // Zero padding makes out-of-range selects read as disabled, empty channels.
  assign in_pad = (NP*WIDTH)'(in);
  assign mask_pad = NP'(mask);
  assign scan = mode == MODE_SCAN;
  assign start = scan && state == ST_MANUAL;
  assign run = scan && state == ST_SCAN;
  scan_mux_ptr #(.N_CH(N_CH), .DWELL(DWELL), .SEL_W(SEL_W)) u_ptr (
    .clk(clk),
    .rst(rst),
    .start(start),
    .run(run),
    .en(en),
    .mask(mask),
    .ptr_next(ptr_next),
    .wrap(wrap)
  );
  always_comb begin
    state_next = scan ? ST_SCAN : ST_MANUAL;
    ch_d = scan ? ptr_next : s;
    v_d = scan ? |mask : mask_pad[s];
    y_d = v_d ? in_pad[ch_d*WIDTH +: WIDTH] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_MANUAL;
      y <= '0;
      y_valid <= 1'b0;
      y_ch <= '0;
    end else begin
      state <= state_next;
      y <= y_d;
      y_valid <= v_d;
      y_ch <= ch_d;
    end
  end
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed bench for scan_mux (8ch/DWELL=4, 6ch, 8ch/DWELL=1); mask vectors under SCAN_MUX_MASK_EN.
module tb_scan_mux;
  logic clk, rst, mode, en;
  logic [7:0] in8, in1, pat;
  logic [5:0] in6;
  logic [2:0] s8, s6;
  logic y8, v8, w8, y6, v6, w6, y1, v1, w1;
  logic [2:0] c8, c6, c1;
  int checks = 0;
  int errors = 0;
`ifdef SCAN_MUX_MASK_EN
  logic [7:0] m8, m1;
  logic [5:0] m6;
`endif
  scan_mux #(.N_CH(8), .WIDTH(1), .DWELL(4)) u8 (
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(m8),
`endif
    .clk(clk), .rst(rst), .in(in8), .s(s8), .mode(mode), .en(en),
    .y(y8), .y_valid(v8), .y_ch(c8), .wrap(w8));
  scan_mux #(.N_CH(6), .WIDTH(1), .DWELL(4)) u6 (
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(m6),
`endif
    .clk(clk), .rst(rst), .in(in6), .s(s6), .mode(mode), .en(en),
    .y(y6), .y_valid(v6), .y_ch(c6), .wrap(w6));
  scan_mux #(.N_CH(8), .WIDTH(1), .DWELL(1)) u1 (
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(m1),
`endif
    .clk(clk), .rst(rst), .in(in1), .s(s8), .mode(mode), .en(en),
    .y(y1), .y_valid(v1), .y_ch(c1), .wrap(w1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1; mode = 1'b0; en = 1'b1;
    in8 = 8'b0000_0100; s8 = 3'd2; in6 = 6'b00_0100; s6 = 3'd7; in1 = 8'hA5; pat = 8'hA5;
`ifdef SCAN_MUX_MASK_EN
    m8 = 8'hFF; m6 = 6'h3F; m1 = 8'hFF;
`endif
    tick(); tick();
    chk("rst_y", y8, 0); chk("rst_valid", v8, 0); chk("rst_ch", c8, 0); chk("rst_wrap", w8, 0);
    rst = 1'b0;
    tick();
    chk("man_y", y8, 1); chk("man_ch", c8, 2); chk("man_valid", v8, 1);
    chk("oor_y", y6, 0); chk("oor_valid", v6, 0); chk("oor_ch", c6, 7);
    s8 = 3'd3;
    tick();
    chk("man3_y", y8, 0); chk("man3_ch", c8, 3); chk("man3_valid", v8, 1);
    in8 = 8'hA5; mode = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      tick();
      chk("scan_ch", c8, (i / 4) % 8);
      chk("scan_y", y8, pat[(i / 4) % 8]);
      chk("scan_valid", v8, 1);
      chk("scan_wrap", w8, i == 32);
      chk("d1_ch", c1, i % 8);
      chk("d1_wrap", w1, i > 0 && i % 8 == 0);
    end
    repeat (13) tick();
    chk("pre_freeze_ch", c8, 3);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("freeze_ch", c8, 3); chk("freeze_wrap", w8, 0);
    end
    en = 1'b1;
    tick(); chk("resume_ch_a", c8, 3);
    tick(); chk("resume_ch_b", c8, 3);
    tick(); chk("resume_ch_c", c8, 4);
    repeat (5) tick();
    chk("pre_switch_ch", c8, 5);
    mode = 1'b0; s8 = 3'd1;
    tick();
    chk("switch_ch", c8, 1); chk("switch_y", y8, 0); chk("switch_valid", v8, 1);
    mode = 1'b1;
    tick();
    chk("reentry_ch", c8, 0); chk("reentry_y", y8, 1); chk("reentry_wrap", w8, 0);
    repeat (4) tick();
    chk("reentry_adv_ch", c8, 1);
    repeat (22) tick();
    chk("pre_rst_ch", c8, 6);
    rst = 1'b1;
    tick();
    chk("midrst_y", y8, 0); chk("midrst_valid", v8, 0); chk("midrst_ch", c8, 0); chk("midrst_wrap", w8, 0);
    rst = 1'b0;
    tick(); chk("post_rst_entry_ch", c8, 0);
    repeat (3) tick(); chk("post_rst_dwell_ch", c8, 0);
    tick(); chk("post_rst_adv_ch", c8, 1);
`ifdef SCAN_MUX_MASK_EN
    mode = 1'b0;
    tick();
    m1 = 8'b1001_0010; mode = 1'b1;
    tick(); chk("mask_ch_a", c1, 1); chk("mask_valid", v1, 1); chk("mask_wrap_a", w1, 0);
    tick(); chk("mask_ch_b", c1, 4); chk("mask_wrap_b", w1, 0);
    tick(); chk("mask_ch_c", c1, 7); chk("mask_y_c", y1, 1);
    tick(); chk("mask_ch_d", c1, 1); chk("mask_wrap_d", w1, 1);
    m1 = 8'h00;
    tick(); chk("mask0_valid", v1, 0); chk("mask0_y", y1, 0); chk("mask0_ch", c1, 1);
    m1 = 8'b1001_0010;
    tick(); chk("mask_back_ch", c1, 4); chk("mask_back_valid", v1, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
